instr_queue: RTL and testbench

Decode-side instruction queue: the consumer end of the fetch-to-decode link. It accepts the two 16-bit words presented by fetch each cycle on `instr1`/`instr2` and drops zero-word bubbles. It buffers the rest in order in a circular queue and presents up to two head entries per cycle to the issue stage. It drives `stall` back to fetch to throttle it, and it clears on `flush` when a branch is taken.

---
 rtl/instr_queue.sv | 119 +++++++++++
 tb/tb_instr_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// instr_queue: decode-side circular instruction queue between fetch and issue.
// Optional feature macro: IQ_STALL_STATS_EN adds the saturating stall_cycles output.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] instr1,
  input  logic [WIDTH-1:0] instr2,
  output logic             stall,
  input  logic [1:0]       deq_count,
  output logic [1:0]       out_valid,
  output logic [WIDTH-1:0] out_instr1,
  output logic [WIDTH-1:0] out_instr2,
  output logic             overflow_err
`ifdef IQ_STALL_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    head_reg, head_next, tail_reg, tail_next;
  logic [PW-1:0]    head_plus1, tail_plus1;
  logic [CW-1:0]    occ_reg, occ_next;
  logic [CW-1:0]    space, deq_ext, req_ext, enq_ext;
  logic             stall_reg, stall_next;
  logic             overflow_reg, overflow_next;
  logic [1:0]       deq_eff, enq_req, enq;
  logic             v1, v2;
  logic [WIDTH-1:0] first_word;

  always_comb begin
    head_plus1 = head_reg + PW'(1);
    tail_plus1 = tail_reg + PW'(1);

    // Head presentation comes from registered state only; no enqueue bypass.
    out_valid  = (occ_reg >= CW'(2)) ? 2'd2 : occ_reg[1:0];
    out_instr1 = (out_valid != 2'd0) ? mem[head_reg] : '0;
    out_instr2 = (out_valid == 2'd2) ? mem[head_plus1] : '0;

    deq_eff    = (deq_count > out_valid) ? out_valid : deq_count;
    v1         = |instr1;
    v2         = |instr2;
    enq_req    = {1'b0, v1} + {1'b0, v2};
    first_word = v1 ? instr1 : instr2;

    // Dequeue this cycle frees space, so a full queue can still accept.
    deq_ext       = CW'(deq_eff);
    req_ext       = CW'(enq_req);
    space         = CW'(DEPTH) - occ_reg + deq_ext;
    overflow_next = overflow_reg;
    enq           = enq_req;
    if (req_ext > space) begin
      enq           = space[1:0];
      overflow_next = 1'b1;
    end
    enq_ext   = CW'(enq);
    occ_next  = occ_reg - deq_ext + enq_ext;
    head_next = head_reg + PW'(deq_eff);
    tail_next = tail_reg + PW'(enq);

    if (flush) begin
      enq           = 2'd0;
      occ_next      = '0;
      head_next     = '0;
      tail_next     = '0;
      overflow_next = overflow_reg;
    end

    // Margin covers one in-flight pair plus one more from fetch's output register.
    stall_next = (occ_next > CW'(DEPTH - 4));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      occ_reg      <= '0;
      stall_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      occ_reg      <= occ_next;
      stall_reg    <= stall_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: entries are only visible while counted in occ.
  always_ff @(posedge clk) begin
    if (reset && (enq != 2'd0)) mem[tail_reg] <= first_word;
    if (reset && (enq == 2'd2)) mem[tail_plus1] <= instr2;
  end

  assign stall        = stall_reg;
  assign overflow_err = overflow_reg;

`ifdef IQ_STALL_STATS_EN
  logic [15:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
    end else if (stall_reg && (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Testbench for instr_queue: directed stimulus with a queue-based scoreboard
// checked by a separate dequeue monitor.
module tb_instr_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] instr1;
  logic [WIDTH-1:0] instr2;
  logic             stall;
  logic [1:0]       deq_count;
  logic [1:0]       out_valid;
  logic [WIDTH-1:0] out_instr1;
  logic [WIDTH-1:0] out_instr2;
  logic             overflow_err;
`ifdef IQ_STALL_STATS_EN
  logic [15:0]      stall_cycles;
`endif

  instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .instr1       (instr1),
    .instr2       (instr2),
    .stall        (stall),
    .deq_count    (deq_count),
    .out_valid    (out_valid),
    .out_instr1   (out_instr1),
    .out_instr2   (out_instr2),
    .overflow_err (overflow_err)
`ifdef IQ_STALL_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];     // reference queue contents
  logic [WIDTH-1:0] exp_q[$];  // words expected to leave the DUT this cycle
  bit               m_stall;
  bit               m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT hands words to issue, pop and compare.
  always @(negedge clk) begin
    int n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] e;
    if (reset && !flush) begin
      n = (deq_count < out_valid) ? int'(deq_count) : int'(out_valid);
      for (int k = 0; k < n; k++) begin
        a = (k == 0) ? out_instr1 : out_instr2;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_pop: DUT delivered %0h, expected no word", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL mon_data: got %0h expected %0h", a, e);
          end
        end
      end
    end
  end

  task automatic step(input string name, input logic [WIDTH-1:0] i1, input logic [WIDTH-1:0] i2,
                      input logic [1:0] dq, input logic fl);
    int ov;
    int de;
    logic [WIDTH-1:0] w[$];
    instr1    = i1;
    instr2    = i2;
    deq_count = dq;
    flush     = fl;
    ov = (mq.size() >= 2) ? 2 : mq.size();
    de = (int'(dq) < ov) ? int'(dq) : ov;
    if (fl) begin
      mq.delete();
      m_stall = 1'b0;
    end else begin
      for (int k = 0; k < de; k++) exp_q.push_back(mq.pop_front());
      if (i1 != 0) w.push_back(i1);
      if (i2 != 0) w.push_back(i2);
      foreach (w[k]) begin
        if (mq.size() < DEPTH) mq.push_back(w[k]);
        else m_ovf = 1'b1;
      end
      m_stall = (mq.size() > DEPTH - 4);
    end
    @(posedge clk);
    #1;
    instr1 = '0; instr2 = '0; deq_count = 2'd0; flush = 1'b0;
    chk({name, "_valid"}, {30'd0, out_valid}, (mq.size() >= 2) ? 32'd2 : 32'(mq.size()));
    chk({name, "_i1"}, {16'd0, out_instr1}, (mq.size() > 0) ? {16'd0, mq[0]} : 32'd0);
    chk({name, "_i2"}, {16'd0, out_instr2}, (mq.size() > 1) ? {16'd0, mq[1]} : 32'd0);
    chk({name, "_stall"}, {31'd0, stall}, {31'd0, m_stall});
    chk({name, "_ovf"}, {31'd0, overflow_err}, {31'd0, m_ovf});
    $display("step %s in=%h/%h dq=%0d fl=%0b -> valid=%0d out=%h/%h stall=%0b ovf=%0b",
             name, i1, i2, dq, fl, out_valid, out_instr1, out_instr2, stall, overflow_err);
  endtask

  task automatic do_reset(input logic fl, input logic [WIDTH-1:0] i1, input logic [WIDTH-1:0] i2);
    reset = 1'b0; flush = fl; instr1 = i1; instr2 = i2; deq_count = 2'd2;
    mq.delete();
    exp_q.delete();
    m_stall = 1'b0;
    m_ovf   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1; flush = 1'b0; instr1 = '0; instr2 = '0; deq_count = 2'd0;
    chk("rst_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_i1", {16'd0, out_instr1}, 32'd0);
    chk("rst_i2", {16'd0, out_instr2}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    $display("reset done: valid=%0d stall=%0b ovf=%0b", out_valid, stall, overflow_err);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; instr1 = '0; instr2 = '0; deq_count = 2'd0;
    m_stall = 1'b0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, '0, '0);

    // Fill: occupancy 2, 4, 6, 8
    step("fill0", 16'h1001, 16'h1002, 2'd0, 1'b0);
    chk("fill_valid", {30'd0, out_valid}, 32'd2);
    chk("fill_i1", {16'd0, out_instr1}, 32'h1001);
    chk("fill_i2", {16'd0, out_instr2}, 32'h1002);
    step("fill1", 16'h1003, 16'h1004, 2'd0, 1'b0);
    chk("occ4_stall", {31'd0, stall}, 32'd0);
    step("fill2", 16'h1005, 16'h1006, 2'd0, 1'b0);
    chk("occ6_stall", {31'd0, stall}, 32'd1);
    step("fill3", 16'h1007, 16'h1008, 2'd0, 1'b0);

    // Full with concurrent dequeue of two
    step("full_deq", 16'h3001, 16'h3002, 2'd2, 1'b0);
    chk("full_deq_ovf", {31'd0, overflow_err}, 32'd0);
    chk("full_deq_stall", {31'd0, stall}, 32'd1);

    // Full, dequeue one: 0x4002 dropped
    step("ovf", 16'h4001, 16'h4002, 2'd1, 1'b0);
    chk("ovf_set", {31'd0, overflow_err}, 32'd1);

    // Drain: expected order 1004..1008, 3001, 3002, 4001
    for (int k = 0; k < 4; k++) step($sformatf("drain%0d", k), '0, '0, 2'd2, 1'b0);
    chk("drain_valid", {30'd0, out_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);

    // Bubble filtering
    step("bubble", 16'h0000, 16'h2222, 2'd0, 1'b0);
    chk("bub_valid", {30'd0, out_valid}, 32'd1);
    chk("bub_i1", {16'd0, out_instr1}, 32'h2222);
    chk("bub_i2", {16'd0, out_instr2}, 32'h0);
    step("bub_deq", '0, '0, 2'd2, 1'b0);
    step("empty_deq", '0, '0, 2'd2, 1'b0);
    chk("empty_valid", {30'd0, out_valid}, 32'd0);

    // Flush with 5 queued
    step("pf0", 16'hA001, 16'hA002, 2'd0, 1'b0);
    step("pf1", 16'hA003, 16'hA004, 2'd0, 1'b0);
    step("pf2", 16'hA005, 16'h0000, 2'd0, 1'b0);
    step("flush", 16'h5001, 16'h5002, 2'd2, 1'b1);
    chk("flush_valid", {30'd0, out_valid}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_ovf_held", {31'd0, overflow_err}, 32'd1);
    step("post_flush", '0, '0, 2'd2, 1'b0);

    // 20 mixed cycles crossing the pointer wrap
    for (int k = 0; k < 20; k++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = (k % 5 == 3) ? 16'h0000 : 16'(16'h6000 + 2 * k + 1);
      b = (k % 4 == 2) ? 16'h0000 : 16'(16'h6000 + 2 * k + 2);
      step($sformatf("mix%0d", k), a, b, 2'(k % 3), 1'b0);
    end

    // Reset mid-stream, asserted together with flush and a pair
    do_reset(1'b1, 16'h7001, 16'h7002);
    step("post_rst", '0, '0, 2'd2, 1'b0);
    chk("post_rst_valid", {30'd0, out_valid}, 32'd0);

    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
